// File: rtl/mha_pkg.sv
// Shared definitions for the multi-head attention datapath.
// Holds the tile geometry, the O-port addressing widths (also used by
// bram_manager) and the write-back FSM state encoding.
package mha_pkg;

    localparam int DATA_W = 8;          // element width in bits
    localparam int TILE   = 16;         // tile edge length in elements
    localparam int LINE_W = 6;          // width of the O line select
    localparam int COL_W  = 3;          // width of the O column select
    localparam int N_COL  = 4;          // tile columns per line, <= 2**COL_W
    localparam int CNT_W  = LINE_W + COL_W; // wide enough for NUM_LINES*N_COL

    typedef logic [0:TILE-1][0:TILE-1][DATA_W-1:0] tile_t;

    typedef enum logic [1:0] {
        WB_IDLE  = 2'd0,
        WB_RUN   = 2'd1,
        WB_FLUSH = 2'd2,
        WB_DONE  = 2'd3
    } wb_state_e;

    // Total tile writes for a run of 'lines' lines.
    function automatic logic [CNT_W-1:0] tile_count(input logic [LINE_W-1:0] lines);
        return CNT_W'(lines) * CNT_W'(N_COL);
    endfunction

endpackage

// File: rtl/tile_addr_gen.sv
// Line/column address walker for the O tile grid.
// Walks line-major, column-minor from a base line; the line counter wraps
// modulo 2**LINE_W. Tracks the remaining tile count and flags the last one.
//
// Ports:
//   I_CLK, I_RST_N : clock, asynchronous active-low reset
//   I_LOAD         : load base line, clear column, load tile count
//   I_BASE_LINE    : first line of the run
//   I_NUM_LINES    : number of lines in the run
//   I_ADV          : advance by one tile (an accepted handshake)
//   O_LINE, O_COL  : address of the tile that the next handshake carries
//   O_LAST         : the next handshake carries the final tile
module tile_addr_gen
    import mha_pkg::*;
(
    input  logic              I_CLK,
    input  logic              I_RST_N,
    input  logic              I_LOAD,
    input  logic [LINE_W-1:0] I_BASE_LINE,
    input  logic [LINE_W-1:0] I_NUM_LINES,
    input  logic              I_ADV,
    output logic [LINE_W-1:0] O_LINE,
    output logic [COL_W-1:0]  O_COL,
    output logic              O_LAST
);

    logic [CNT_W-1:0] tiles_left;

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            O_LINE     <= '0;
            O_COL      <= '0;
            tiles_left <= '0;
        end else if (I_LOAD) begin
            O_LINE     <= I_BASE_LINE;
            O_COL      <= '0;
            tiles_left <= tile_count(I_NUM_LINES);
        end else if (I_ADV) begin
            tiles_left <= tiles_left - CNT_W'(1);
            if (O_COL == COL_W'(N_COL - 1)) begin
                O_COL  <= '0;
                // Natural overflow gives the 63 -> 0 line wrap.
                O_LINE <= O_LINE + LINE_W'(1);
            end else begin
                O_COL <= O_COL + COL_W'(1);
            end
        end
    end

    assign O_LAST = (tiles_left == CNT_W'(1));

endmodule

// File: rtl/o_tile_writeback.sv
// Write-back stage in front of the bram_manager O port.
// Accepts finished output tiles over a valid/ready handshake and turns each
// into a one-cycle ENA_O/WEA_O write strobe with its line/column address.
//
// Handshake: a tile transfers on a rising edge where I_TILE_VLD and
// O_TILE_RDY are both high. O_TILE_RDY depends only on the FSM state and
// never on I_TILE_VLD; upstream must hold I_TILE stable while VLD is high
// and RDY is low.
//
// Ports:
//   I_CLK, I_RST_N           : clock, asynchronous active-low reset
//   I_START                  : start pulse, honoured only in IDLE
//   I_BASE_LINE, I_NUM_LINES : run geometry, sampled with I_START
//   I_TILE_VLD, O_TILE_RDY, I_TILE : upstream tile handshake
//   O_ENA_O, O_WEA_O, O_SEL_O_LINE, O_SEL_O_COL, O_MAT : to bram_manager
//   O_BUSY                   : run in progress (accepted start up to DONE)
//   O_DONE                   : one-cycle pulse after the final write strobe
//   O_STATE                  : current FSM state, for debug/checkers
module o_tile_writeback
    import mha_pkg::*;
(
    input  logic                                    I_CLK,
    input  logic                                    I_RST_N,
    input  logic                                    I_START,
    input  logic [LINE_W-1:0]                       I_BASE_LINE,
    input  logic [LINE_W-1:0]                       I_NUM_LINES,
    input  logic                                    I_TILE_VLD,
    output logic                                    O_TILE_RDY,
    input  logic [0:TILE-1][0:TILE-1][DATA_W-1:0]   I_TILE,
    output logic                                    O_ENA_O,
    output logic                                    O_WEA_O,
    output logic [LINE_W-1:0]                       O_SEL_O_LINE,
    output logic [COL_W-1:0]                        O_SEL_O_COL,
    output logic [0:TILE-1][0:TILE-1][DATA_W-1:0]   O_MAT,
    output logic                                    O_BUSY,
    output logic                                    O_DONE,
    output logic [1:0]                              O_STATE
);

    wb_state_e         state;
    logic              load;
    logic              handshake;
    logic [LINE_W-1:0] line_cnt;
    logic [COL_W-1:0]  col_cnt;
    logic              last_tile;

    assign O_TILE_RDY = (state == WB_RUN);
    assign handshake  = O_TILE_RDY && I_TILE_VLD;
    // A zero-line start goes straight to DONE and never touches the counters.
    assign load       = (state == WB_IDLE) && I_START && (I_NUM_LINES != '0);
    assign O_STATE    = state;

    tile_addr_gen u_addr (
        .I_CLK       (I_CLK),
        .I_RST_N     (I_RST_N),
        .I_LOAD      (load),
        .I_BASE_LINE (I_BASE_LINE),
        .I_NUM_LINES (I_NUM_LINES),
        .I_ADV       (handshake),
        .O_LINE      (line_cnt),
        .O_COL       (col_cnt),
        .O_LAST      (last_tile)
    );

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            state        <= WB_IDLE;
            O_ENA_O      <= 1'b0;
            O_WEA_O      <= 1'b0;
            O_SEL_O_LINE <= '0;
            O_SEL_O_COL  <= '0;
            O_MAT        <= '0;
            O_BUSY       <= 1'b0;
            O_DONE       <= 1'b0;
        end else begin
            // Strobes are single-cycle; O_MAT and SEL hold between writes.
            O_ENA_O <= 1'b0;
            O_WEA_O <= 1'b0;
            O_DONE  <= 1'b0;
            case (state)
                WB_IDLE: begin
                    if (I_START) begin
                        if (I_NUM_LINES != '0) begin
                            state  <= WB_RUN;
                            O_BUSY <= 1'b1;
                        end else begin
                            state  <= WB_DONE;
                            O_DONE <= 1'b1;
                        end
                    end
                end
                WB_RUN: begin
                    if (handshake) begin
                        O_MAT        <= I_TILE;
                        O_SEL_O_LINE <= line_cnt;
                        O_SEL_O_COL  <= col_cnt;
                        O_ENA_O      <= 1'b1;
                        O_WEA_O      <= 1'b1;
                        if (last_tile) begin
                            state <= WB_FLUSH;
                        end
                    end
                end
                WB_FLUSH: begin
                    // Final strobe is on the outputs during this cycle.
                    state  <= WB_DONE;
                    O_DONE <= 1'b1;
                end
                WB_DONE: begin
                    state  <= WB_IDLE;
                    O_BUSY <= 1'b0;
                end
                default: state <= WB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_o_tile_writeback.sv
module tb_o_tile_writeback;
  import mha_pkg::*;

  localparam int W = LINE_W + COL_W + TILE*TILE*DATA_W;

  logic              I_CLK;
  logic              I_RST_N;
  logic              I_START;
  logic [LINE_W-1:0] I_BASE_LINE;
  logic [LINE_W-1:0] I_NUM_LINES;
  logic              I_TILE_VLD;
  logic              O_TILE_RDY;
  tile_t             I_TILE;
  logic              O_ENA_O;
  logic              O_WEA_O;
  logic [LINE_W-1:0] O_SEL_O_LINE;
  logic [COL_W-1:0]  O_SEL_O_COL;
  tile_t             O_MAT;
  logic              O_BUSY;
  logic              O_DONE;
  logic [1:0]        O_STATE;

  int n_checks = 0;
  int n_fail   = 0;
  int done_seen = 0;
  logic [W-1:0] exp_q[$];

  o_tile_writeback dut (
    .I_CLK        (I_CLK),
    .I_RST_N      (I_RST_N),
    .I_START      (I_START),
    .I_BASE_LINE  (I_BASE_LINE),
    .I_NUM_LINES  (I_NUM_LINES),
    .I_TILE_VLD   (I_TILE_VLD),
    .O_TILE_RDY   (O_TILE_RDY),
    .I_TILE       (I_TILE),
    .O_ENA_O      (O_ENA_O),
    .O_WEA_O      (O_WEA_O),
    .O_SEL_O_LINE (O_SEL_O_LINE),
    .O_SEL_O_COL  (O_SEL_O_COL),
    .O_MAT        (O_MAT),
    .O_BUSY       (O_BUSY),
    .O_DONE       (O_DONE),
    .O_STATE      (O_STATE)
  );

  // ---------------- clock / reset ----------------
  initial begin
    I_CLK = 1'b0;
    forever #5 I_CLK = ~I_CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  // ---------------- helpers ----------------
  function automatic tile_t make_tile(input logic [7:0] f);
    tile_t t;
    for (int r = 0; r < TILE; r++)
      for (int c = 0; c < TILE; c++)
        t[r][c] = f + 8'(r*16 + c);
    return t;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // All drive points are 1 time unit after a rising edge.
  task automatic start_run(input logic [LINE_W-1:0] base, input logic [LINE_W-1:0] num);
    I_BASE_LINE = base;
    I_NUM_LINES = num;
    I_START = 1'b1;
    @(posedge I_CLK); #1;
    I_START = 1'b0;
  endtask

  task automatic send_tile(input logic [7:0] f, input logic [LINE_W-1:0] line,
                           input logic [COL_W-1:0] col, output int waited);
    int n;
    n = 0;
    I_TILE_VLD = 1'b1;
    I_TILE = make_tile(f);
    while (!O_TILE_RDY && n < 50) begin
      @(posedge I_CLK); #1;
      n++;
    end
    waited = n;
    n_checks++;
    if (!O_TILE_RDY) begin
      n_fail++;
      $display("FAIL rdy_timeout: got rdy 0 after %0d cycles, expected rdy 1", n);
      I_TILE_VLD = 1'b0;
    end else begin
      exp_q.push_back({line, col, make_tile(f)});
      @(posedge I_CLK); #1;
      I_TILE_VLD = 1'b0;
    end
  endtask

  task automatic idle_cycle();
    @(posedge I_CLK); #1;
  endtask

  // Waits on negedges for O_DONE; returns on that negedge.
  task automatic wait_done(input string name, input int exp_n, input int exp_busy);
    int n;
    n = 0;
    do begin
      @(negedge I_CLK);
      n++;
    end while (!O_DONE && n < 20);
    check({name, "_done_latency"}, n, exp_n);
    check({name, "_busy_at_done"}, O_BUSY, exp_busy);
    @(posedge I_CLK); #1;
    check({name, "_done_cleared"}, O_DONE, 0);
    check({name, "_busy_after"}, O_BUSY, 0);
    check({name, "_state_idle"}, O_STATE, WB_IDLE);
    check({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge I_CLK) begin
    if (I_RST_N) begin
      if (O_ENA_O || O_WEA_O) begin
        logic [W-1:0] e;
        logic [W-1:0] act;
        n_checks++;
        act = {O_SEL_O_LINE, O_SEL_O_COL, O_MAT};
        if (O_ENA_O !== O_WEA_O) begin
          n_fail++;
          $display("FAIL ena_wea: got ena %0b wea %0b, expected equal", O_ENA_O, O_WEA_O);
        end else if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_strobe: got write line %0d col %0d, expected no write",
                   O_SEL_O_LINE, O_SEL_O_COL);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            n_fail++;
            $display("FAIL write: got line %0d col %0d mat00 %0h, expected line %0d col %0d mat00 %0h (or tile body differs)",
                     O_SEL_O_LINE, O_SEL_O_COL, O_MAT[0][0],
                     e[W-1 -: LINE_W], e[W-LINE_W-1 -: COL_W], e[TILE*TILE*DATA_W-1 -: DATA_W]);
          end
        end
      end
      if (O_DONE) done_seen++;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int w;
    int wsum;
    logic [7:0] fills [4];
    fills[0] = 8'h55; fills[1] = 8'h66; fills[2] = 8'h77; fills[3] = 8'h88;

    I_RST_N = 1'b0;
    I_START = 1'b0;
    I_BASE_LINE = '0;
    I_NUM_LINES = '0;
    I_TILE_VLD = 1'b0;
    I_TILE = make_tile(8'hA5);
    repeat (3) @(negedge I_CLK);

    // Reset values
    check("rst_rdy", O_TILE_RDY, 0);
    check("rst_ena", O_ENA_O, 0);
    check("rst_wea", O_WEA_O, 0);
    check("rst_busy", O_BUSY, 0);
    check("rst_done", O_DONE, 0);
    check("rst_line", O_SEL_O_LINE, 0);
    check("rst_col", O_SEL_O_COL, 0);
    check("rst_mat_zero", (O_MAT == '0) ? 1 : 0, 1);
    check("rst_state", O_STATE, WB_IDLE);
    I_RST_N = 1'b1;
    idle_cycle();

    // VLD while IDLE: never ready
    I_TILE_VLD = 1'b1;
    idle_cycle();
    check("idle_rdy_low", O_TILE_RDY, 0);
    I_TILE_VLD = 1'b0;

    // A: base 2, one line, VLD held high (back-to-back)
    start_run(6'd2, 6'd1);
    check("a_busy", O_BUSY, 1);
    check("a_rdy", O_TILE_RDY, 1);
    wsum = 0;
    for (int i = 0; i < 4; i++) begin
      send_tile(fills[i], 6'd2, 3'(i), w);
      wsum += w;
    end
    check("a_back_to_back_waits", wsum, 0);
    check("a_rdy_drop_after_last", O_TILE_RDY, 0);
    wait_done("a", 2, 1);

    // B: same run, VLD toggling 1,0,1,0
    start_run(6'd2, 6'd1);
    for (int i = 0; i < 4; i++) begin
      send_tile(fills[i] ^ 8'hFF, 6'd2, 3'(i), w);
      idle_cycle();
    end
    wait_done("b", 1, 1);

    // C: base 63, two lines -> wrap to line 0
    start_run(6'd63, 6'd2);
    for (int i = 0; i < 8; i++)
      send_tile(8'(8'h10 + i), (i < 4) ? 6'd63 : 6'd0, 3'(i % 4), w);
    wait_done("c", 2, 1);

    // D: zero-line start -> straight to DONE, no writes, busy stays low
    start_run(6'd9, 6'd0);
    check("d_busy_low", O_BUSY, 0);
    wait_done("d", 1, 0);

    // E: start re-pulsed during RUN with a different base is ignored
    start_run(6'd20, 6'd1);
    send_tile(8'h31, 6'd20, 3'd0, w);
    I_BASE_LINE = 6'd40;
    I_NUM_LINES = 6'd3;
    I_START = 1'b1;
    idle_cycle();
    I_START = 1'b0;
    for (int i = 1; i < 4; i++)
      send_tile(8'(8'h31 + i), 6'd20, 3'(i), w);
    wait_done("e", 2, 1);

    // F: reset after the 2nd handshake of a 4-tile run
    start_run(6'd5, 6'd1);
    send_tile(8'hC0, 6'd5, 3'd0, w);
    send_tile(8'hC1, 6'd5, 3'd1, w);
    #2;
    I_RST_N = 1'b0;
    #1;
    check("f_rst_ena", O_ENA_O, 0);
    check("f_rst_wea", O_WEA_O, 0);
    check("f_rst_busy", O_BUSY, 0);
    check("f_rst_rdy", O_TILE_RDY, 0);
    check("f_rst_line", O_SEL_O_LINE, 0);
    check("f_rst_col", O_SEL_O_COL, 0);
    check("f_rst_mat_zero", (O_MAT == '0) ? 1 : 0, 1);
    check("f_rst_state", O_STATE, WB_IDLE);
    exp_q.delete();
    repeat (2) @(negedge I_CLK);
    I_RST_N = 1'b1;
    repeat (4) idle_cycle();
    start_run(6'd9, 6'd1);
    for (int i = 0; i < 4; i++)
      send_tile(8'(8'hE0 + i), 6'd9, 3'(i), w);
    wait_done("f", 2, 1);

    repeat (4) idle_cycle();
    check("done_pulse_total", done_seen, 6);
    check("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
